// File: rtl/hex_dump_pkg.sv
// Shared types and ASCII constants for the hex dump sequencer.
// HEX_DUMP_CRLF_EN adds the CR/LF states that terminate each printed word.
package hex_dump_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

`ifdef HEX_DUMP_CRLF_EN
  typedef enum logic [1:0] {StIdle, StEmit, StCr, StLf} state_e;
`else
  typedef enum logic [0:0] {StIdle, StEmit} state_e;
`endif

endpackage

// File: rtl/nibble_to_char.sv
// Combinational map of one hex nibble to its uppercase ASCII character.
module nibble_to_char
  import hex_dump_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'b0000, nibble};
    end else begin
      ascii = ASCII_A + {4'b0000, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_dump_seq.sv
// Prints each accepted word as NIBBLES uppercase hex characters, MSB first.
// Define HEX_DUMP_CRLF_EN to follow every word with CR, LF.
module hex_dump_seq
  import hex_dump_pkg::*;
#(
  parameter int unsigned NIBBLES = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_char,
  output logic                 busy,
  output logic [CNT_W-1:0]     words_done
);

  localparam int unsigned DW   = 4 * NIBBLES;
  localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e            state_q, state_d;
  logic [DW-1:0]     shift_q, shift_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [7:0]        char_q, char_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  done_q, done_d;

  logic [3:0] nibble;
  logic [7:0] nibble_ascii;
  logic       accept;
  logic       take;

  assign accept = in_valid & ready_q;
  assign take   = valid_q & out_ready;

  // shift_q holds only the not-yet-printed nibbles, so in IDLE the first
  // character comes straight from in_data and later ones from the shifter.
  assign nibble = (state_q == StIdle) ? in_data[DW-1 -: 4] : shift_q[DW-1 -: 4];

  nibble_to_char u_nibble_to_char (
    .nibble (nibble),
    .ascii  (nibble_ascii)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    char_d  = char_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = in_data << 4;
          idx_d   = IDXW'(NIBBLES - 1);
          char_d  = nibble_ascii;
          valid_d = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (take) begin
          if (idx_q != '0) begin
            idx_d   = idx_q - IDXW'(1);
            char_d  = nibble_ascii;
            shift_d = shift_q << 4;
          end else begin
`ifdef HEX_DUMP_CRLF_EN
            char_d  = ASCII_CR;
            state_d = StCr;
`else
            valid_d = 1'b0;
            done_d  = done_q + CNT_W'(1);
            state_d = StIdle;
`endif
          end
        end
      end
`ifdef HEX_DUMP_CRLF_EN
      StCr: begin
        if (take) begin
          char_d  = ASCII_LF;
          state_d = StLf;
        end
      end
      StLf: begin
        if (take) begin
          valid_d = 1'b0;
          done_d  = done_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    // Registered so in_ready stays low until the first edge after reset.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_char   = char_q;
  assign busy       = (state_q != StIdle);
  assign words_done = done_q;

endmodule
